// File: rtl/regfile_dbg_access_ctrl_pkg.sv
// Shared types and defaults for the register-file debug access sequencer.
package regfile_dbg_access_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int RD_WIDTH_DEF   = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STALL  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
  } dbg_state_e;

  // Width of a counter able to hold 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/regfile_dbg_access_ctrl_dbg_starve_counter.sv
// Saturating count of WB-busy wait cycles; hit flags that the limit is reached.
module dbg_starve_counter
  import regfile_dbg_access_ctrl_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_r;

  // Counter register: clear wins, increment stops at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (inc && (count_r != LIMIT_C)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == LIMIT_C);

endmodule

// File: rtl/regfile_dbg_access_ctrl.sv
// Debug-port sequencer for the register file: waits for a WB-free cycle,
// forcing a WB stall after too many busy cycles, then performs and acks the access.
module regfile_dbg_access_ctrl
  import regfile_dbg_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = RD_WIDTH_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic                  wb_valid,
  input  logic                  wb_ready_go,
  output logic                  wb_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  busy,
  output logic                  rf_jtag_we,
  output logic [ADDR_WIDTH-1:0] rf_jtag_addr,
  output logic [DATA_WIDTH-1:0] rf_jtag_wdata,
  input  logic [DATA_WIDTH-1:0] rf_jtag_rdata
);

  dbg_state_e            state_r;
  dbg_state_e            state_s;
  logic                  lat_we_r;
  logic [ADDR_WIDTH-1:0] lat_addr_r;
  logic [DATA_WIDTH-1:0] lat_wdata_r;
  logic                  from_stall_r;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic                  wb_req_s;
  logic                  cnt_clr_s;
  logic                  cnt_inc_s;
  logic                  cnt_hit_s;

  assign wb_req_s = wb_we & wb_valid & wb_ready_go;

  dbg_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .inc (cnt_inc_s),
    .hit (cnt_hit_s)
  );

  // Next-state and counter control.
  always_comb begin
    state_s   = state_r;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dbg_req) begin
          state_s   = ST_WAIT;
          cnt_clr_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!wb_req_s) begin
          state_s = ST_ACCESS;
        end else if (cnt_hit_s) begin
          state_s = ST_STALL;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_STALL:  state_s = ST_ACCESS;
      // A collision sends even a read back to WAIT, keeping the starvation count.
      ST_ACCESS: begin
        if (wb_req_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, request latch, stall-origin flag and read-data holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      lat_we_r     <= 1'b0;
      lat_addr_r   <= {ADDR_WIDTH{1'b0}};
      lat_wdata_r  <= {DATA_WIDTH{1'b0}};
      from_stall_r <= 1'b0;
      rdata_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      from_stall_r <= (state_r == ST_STALL);
      if ((state_r == ST_IDLE) && dbg_req) begin
        lat_we_r    <= dbg_we;
        lat_addr_r  <= dbg_addr;
        lat_wdata_r <= dbg_wdata;
      end
      if ((state_r == ST_ACCESS) && !wb_req_s && !lat_we_r) begin
        rdata_r <= rf_jtag_rdata;
      end
    end
  end

  // Output decode; only the regfile write enable looks at the live WB request.
  always_comb begin
    busy       = (state_r != ST_IDLE);
    dbg_ack    = (state_r == ST_DONE);
    wb_stall   = (state_r == ST_STALL) || ((state_r == ST_ACCESS) && from_stall_r);
    rf_jtag_we = (state_r == ST_ACCESS) && lat_we_r && !wb_req_s;
    if (state_r == ST_IDLE) begin
      rf_jtag_addr  = {ADDR_WIDTH{1'b0}};
      rf_jtag_wdata = {DATA_WIDTH{1'b0}};
    end else begin
      rf_jtag_addr  = lat_addr_r;
      rf_jtag_wdata = lat_wdata_r;
    end
  end

  assign dbg_rdata = rdata_r;

endmodule

// File: tb/tb_regfile_dbg_access_ctrl.sv
// Directed and random checks of regfile_dbg_access_ctrl against a transaction-level model.
module tb_regfile_dbg_access_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_we = 1'b0, wb_valid = 1'b0, wb_ready_go = 1'b0, wb_stall;
  logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_ack, busy, rf_jtag_we;
  logic [AW-1:0] dbg_addr = '0, rf_jtag_addr;
  logic [DW-1:0] dbg_wdata = '0, dbg_rdata, rf_jtag_wdata, rf_jtag_rdata;

  logic          wb_rg_raw = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic [DW-1:0] rf   [32];
  logic [DW-1:0] m_rf [32];

  // Model of the outstanding access, kept as plain flags and a wait count.
  logic          m_pend, m_we, m_stall_now, m_try_now, m_forced, m_ack_now;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            m_cnt;

  int n_cmp = 0, n_err = 0, cyc = 0, n_acks = 0, last_ack = -1, prev_ack = -1, stall_cycles = 0;

  always #5 clk = ~clk;

  assign rf_jtag_rdata = (rf_jtag_addr == 5'd0) ? 32'd0 : rf[rf_jtag_addr];

  regfile_dbg_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_valid(wb_valid), .wb_ready_go(wb_ready_go),
    .wb_stall(wb_stall), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .busy(busy),
    .rf_jtag_we(rf_jtag_we), .rf_jtag_addr(rf_jtag_addr), .rf_jtag_wdata(rf_jtag_wdata),
    .rf_jtag_rdata(rf_jtag_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_we = 1'b0; m_stall_now = 1'b0; m_try_now = 1'b0;
    m_forced = 1'b0; m_ack_now = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_ack"},   32'(dbg_ack), 32'd0);
    check({tag, "_stall"}, 32'(wb_stall), 32'd0);
    check({tag, "_we"},    32'(rf_jtag_we), 32'd0);
    check({tag, "_addr"},  32'(rf_jtag_addr), 32'd0);
    check({tag, "_wdata"}, rf_jtag_wdata, 32'd0);
    check({tag, "_rdata"}, dbg_rdata, 32'd0);
  endtask

  // One clock cycle: drive WB handshake, compare against the model, advance both.
  task automatic tick();
    logic          e_stall, e_wbreq, e_we, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    e_stall     = m_stall_now | (m_try_now & m_forced);
    wb_ready_go = wb_rg_raw & ~e_stall;
    e_wbreq     = wb_we & wb_valid & wb_ready_go;
    e_we        = m_try_now & m_we & ~e_wbreq;
    #1;
    check("busy",   32'(busy), 32'(m_pend));
    check("ack",    32'(dbg_ack), 32'(m_ack_now));
    check("stall",  32'(wb_stall), 32'(e_stall));
    check("jtag_we", 32'(rf_jtag_we), 32'(e_we));
    check("jtag_addr", 32'(rf_jtag_addr), m_pend ? 32'(m_addr) : 32'd0);
    check("jtag_wdata", rf_jtag_wdata, m_pend ? m_wdata : 32'd0);
    check("rdata",  dbg_rdata, m_rdata);
    check("no_collision", 32'(rf_jtag_we & e_wbreq), 32'd0);
    if (dbg_ack === 1'b1) begin n_acks++; prev_ack = last_ack; last_ack = cyc; end
    if (wb_stall === 1'b1) stall_cycles++;
    s_we = rf_jtag_we; s_addr = rf_jtag_addr; s_wd = rf_jtag_wdata;
    @(posedge clk);
    if (e_wbreq && wb_addr != 5'd0) begin rf[wb_addr] <= wb_data; m_rf[wb_addr] = wb_data; end
    if (s_we === 1'b1 && s_addr != 5'd0) rf[s_addr] <= s_wd;
    if (e_we && m_addr != 5'd0) m_rf[m_addr] = m_wdata;
    if (!m_pend) begin
      if (dbg_req) begin
        m_pend = 1'b1; m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; m_cnt = 0;
      end
    end else if (m_ack_now) begin
      m_pend = 1'b0; m_ack_now = 1'b0;
    end else if (m_stall_now) begin
      m_stall_now = 1'b0; m_try_now = 1'b1; m_forced = 1'b1;
    end else if (m_try_now) begin
      m_try_now = 1'b0; m_forced = 1'b0;
      if (!e_wbreq) begin
        m_ack_now = 1'b1;
        if (!m_we) m_rdata = (m_addr == 5'd0) ? 32'd0 : m_rf[m_addr];
      end
    end else if (!e_wbreq) begin
      m_try_now = 1'b1; m_forced = 1'b0;
    end else if (m_cnt == LIM) begin
      m_stall_now = 1'b1;
    end else begin
      m_cnt++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wb_set(input logic b);
    wb_we = b; wb_valid = b; wb_rg_raw = b; wb_addr = 5'($urandom); wb_data = $urandom;
  endtask

  // Issue one access with a single-cycle request and wait (bounded) for its ack.
  task automatic access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int req_cyc);
    int base;
    base = n_acks; req_cyc = cyc;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_req = 1'b0;
    for (int i = 0; i < 40 && n_acks == base; i++) tick();
    check("ack_timeout", 32'(n_acks - base), 32'd1);
  endtask

  initial begin
    int k, base;
    logic [2:0] r3;
    for (int i = 0; i < 32; i++) begin
      rf[i] = (i == 0) ? 32'd0 : $urandom; m_rf[i] = rf[i];
    end
    model_reset();
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Uncontended write then read of x5.
    access(1'b1, 5'd5, 32'hDEADBEEF, k);
    check("t1_wr_latency", 32'(last_ack - k), 32'd3);
    access(1'b0, 5'd5, 32'd0, k);
    check("t1_rd_latency", 32'(last_ack - k), 32'd3);
    check("t1_rd_value", dbg_rdata, 32'hDEADBEEF);

    // WB permanently busy: starvation forces a two-cycle stall.
    wb_set(1'b1); stall_cycles = 0;
    access(1'b1, 5'd7, 32'hA5A5_0007, k);
    check("t2_latency", 32'(last_ack - k), 32'd12);
    check("t2_stall_cycles", 32'(stall_cycles), 32'd2);
    tick();
    check("t2_stall_after", 32'(wb_stall), 32'd0);
    wb_set(1'b0);
    access(1'b0, 5'd7, 32'd0, k);
    check("t2_readback", dbg_rdata, 32'hA5A5_0007);

    // Collision in ACCESS: retried, one ack only.
    base = n_acks; k = cyc;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h0000_C0DE;
    tick(); dbg_req = 1'b0;
    tick();
    wb_set(1'b1); tick(); wb_set(1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("t3_ack_count", 32'(n_acks - base), 32'd1);
    check("t3_latency", 32'(last_ack - k), 32'd5);

    // Register x0.
    access(1'b1, 5'd0, 32'h0000_1234, k);
    check("t4_wr_latency", 32'(last_ack - k), 32'd3);
    access(1'b0, 5'd0, 32'd0, k);
    check("t4_rd_value", dbg_rdata, 32'd0);

    // Reset while waiting drops the request.
    base = n_acks;
    wb_set(1'b1);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h5555_AAAA;
    tick(); dbg_req = 1'b0;
    tick();
    rst = 1'b1; #1;
    check_zero("t5_async");
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 1'b0; wb_set(1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_ack", 32'(n_acks - base), 32'd0);

    // Request held through ack: back-to-back accesses four cycles apart.
    base = n_acks;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
    for (int i = 0; i < 20 && (n_acks - base) < 2; i++) tick();
    dbg_req = 1'b0;
    check("t6_two_acks", 32'(n_acks - base), 32'd2);
    check("t6_spacing", 32'(last_ack - prev_ack), 32'd4);
    for (int i = 0; i < 4; i++) tick();

    // Random traffic with phases of light, mixed and heavy WB load.
    for (int p = 0; p < 12; p++) begin
      int pct;
      pct = (p % 3 == 0) ? 10 : ((p % 3 == 1) ? 50 : 97);
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 99) < pct) begin
          wb_set(1'b1);
        end else begin
          r3 = 3'($urandom_range(0, 6));
          wb_we = r3[2]; wb_valid = r3[1]; wb_rg_raw = r3[0];
          wb_addr = 5'($urandom); wb_data = $urandom;
        end
        dbg_req = ($urandom_range(0, 99) < 40); dbg_we = 1'($urandom);
        dbg_addr = 5'($urandom); dbg_wdata = $urandom;
        tick();
      end
    end
    dbg_req = 1'b0; wb_set(1'b0);
    for (int i = 0; i < 30; i++) tick();
    check("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
